backtrack_ctrl: RTL and testbench

BACKTRACK_CTRL -- requirements
Module: backtrack_ctrl

---
 rtl/backtrack_ctrl.sv | 202 ++++++++++++++++++++
 tb/tb_backtrack_ctrl.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/backtrack_ctrl.sv
// -----------------------------------------------------------------------------
// backtrack_ctrl
// Chronological backtracking controller for a DPLL-style SAT solver.
// It records each decision level (polarity and whether both polarities have
// been tried) and steps the decision stack on a conflict:
// - tried levels are unwound one per cycle;
// - the first untried level is flipped to the opposite polarity;
// - running out of levels leaves the block in a sticky UNSAT state.
//
// Ports
//   clk_i, rst_ni        : clock, asynchronous active-low reset
//   decide_valid_i/var_i/val_i : new decision from the decider
//   conflict_i           : one-cycle backtrack request
//   stk_push_o/stk_pop_o/stk_idx_in_o : decision-stack control and data-in
//   stk_idx_out_i        : stack top, valid combinationally while popping
//   unassign_valid_o/var_o : clear a variable's assignment
//   flip_valid_o/var_o/val_o : reassign a variable to the opposite polarity
//   busy_o               : controller is not idle
//   unsat_o, overflow_o  : sticky status flags
// -----------------------------------------------------------------------------
module backtrack_ctrl #(
    parameter int MAX_VARS      = 64,
    parameter int MAX_VARS_BITS = 6
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     decide_valid_i,
    input  logic [MAX_VARS_BITS-1:0] decide_var_i,
    input  logic                     decide_val_i,
    input  logic                     conflict_i,
    output logic                     stk_push_o,
    output logic                     stk_pop_o,
    output logic [MAX_VARS_BITS-1:0] stk_idx_in_o,
    input  logic [MAX_VARS_BITS-1:0] stk_idx_out_i,
    output logic                     unassign_valid_o,
    output logic [MAX_VARS_BITS-1:0] unassign_var_o,
    output logic                     flip_valid_o,
    output logic [MAX_VARS_BITS-1:0] flip_var_o,
    output logic                     flip_val_o,
    output logic                     busy_o,
    output logic                     unsat_o,
    output logic                     overflow_o
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BT    = 2'd1,
        ST_FLIP  = 2'd2,
        ST_UNSAT = 2'd3
    } state_e;

    localparam logic [MAX_VARS_BITS:0] DEPTH_MAX = (MAX_VARS_BITS+1)'(MAX_VARS);
    localparam logic [MAX_VARS_BITS:0] DEPTH_ONE = (MAX_VARS_BITS+1)'(1);

    state_e                   state_q, state_d;
    logic [MAX_VARS_BITS:0]   depth_q, depth_d;
    logic [MAX_VARS_BITS-1:0] var_q, var_d;
    logic                     old_q, old_d;
    logic                     overflow_q, overflow_d;
    logic [MAX_VARS-1:0]      tried_q;
    logic [MAX_VARS-1:0]      val_q;

    // Level write port into the per-level tracking arrays.
    logic                     lvl_we_s;
    logic [MAX_VARS_BITS-1:0] lvl_idx_s;
    logic                     lvl_tried_s;
    logic                     lvl_val_s;

    // Index of the deepest occupied level. When depth == MAX_VARS the low bits
    // wrap to zero, so subtracting one still yields MAX_VARS-1 for a
    // power-of-two MAX_VARS.
    logic [MAX_VARS_BITS-1:0] top_lvl_s;
    assign top_lvl_s = depth_q[MAX_VARS_BITS-1:0] - MAX_VARS_BITS'(1);

    logic                     push_s;
    logic                     pop_s;
    logic [MAX_VARS_BITS-1:0] idx_in_s;
    logic                     unassign_valid_s;
    logic [MAX_VARS_BITS-1:0] unassign_var_s;
    logic                     flip_valid_s;
    logic [MAX_VARS_BITS-1:0] flip_var_s;
    logic                     flip_val_s;

    // Next-state and pulse-output logic of the backtrack FSM.
    always_comb begin
        state_d          = state_q;
        depth_d          = depth_q;
        var_d            = var_q;
        old_d            = old_q;
        overflow_d       = overflow_q;
        lvl_we_s         = 1'b0;
        lvl_idx_s        = depth_q[MAX_VARS_BITS-1:0];
        lvl_tried_s      = 1'b0;
        lvl_val_s        = 1'b0;
        push_s           = 1'b0;
        pop_s            = 1'b0;
        idx_in_s         = '0;
        unassign_valid_s = 1'b0;
        unassign_var_s   = '0;
        flip_valid_s     = 1'b0;
        flip_var_s       = '0;
        flip_val_s       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // Conflict wins over a simultaneous decision.
                if (conflict_i) begin
                    state_d = ST_BT;
                end else if (decide_valid_i) begin
                    if (depth_q < DEPTH_MAX) begin
                        push_s      = 1'b1;
                        idx_in_s    = decide_var_i;
                        lvl_we_s    = 1'b1;
                        lvl_tried_s = 1'b0;
                        lvl_val_s   = decide_val_i;
                        depth_d     = depth_q + DEPTH_ONE;
                    end else begin
                        overflow_d = 1'b1;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_BT: begin
                if (depth_q == '0) begin
                    state_d = ST_UNSAT;
                end else begin
                    pop_s   = 1'b1;
                    depth_d = depth_q - DEPTH_ONE;
                    if (tried_q[top_lvl_s]) begin
                        unassign_valid_s = 1'b1;
                        unassign_var_s   = stk_idx_out_i;
                    end else begin
                        var_d   = stk_idx_out_i;
                        old_d   = val_q[top_lvl_s];
                        state_d = ST_FLIP;
                    end
                end
            end
            ST_FLIP: begin
                // Re-push the flipped variable as a level whose both
                // polarities are now exhausted.
                push_s       = 1'b1;
                idx_in_s     = var_q;
                flip_valid_s = 1'b1;
                flip_var_s   = var_q;
                flip_val_s   = ~old_q;
                lvl_we_s     = 1'b1;
                lvl_tried_s  = 1'b1;
                lvl_val_s    = ~old_q;
                depth_d      = depth_q + DEPTH_ONE;
                state_d      = ST_IDLE;
            end
            ST_UNSAT: begin
                state_d = ST_UNSAT;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // FSM, depth and latched-level registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= ST_IDLE;
            depth_q    <= '0;
            var_q      <= '0;
            old_q      <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            depth_q    <= depth_d;
            var_q      <= var_d;
            old_q      <= old_d;
            overflow_q <= overflow_d;
        end
    end

    // Per-level tracking arrays; unreachable above depth, so never reset.
    always_ff @(posedge clk_i) begin
        if (lvl_we_s) begin
            tried_q[lvl_idx_s] <= lvl_tried_s;
            val_q[lvl_idx_s]   <= lvl_val_s;
        end
    end

    // Pulses are forced low while reset is held so that they clear at once,
    // without waiting for the state register to be observed.
    assign stk_push_o       = rst_ni & push_s;
    assign stk_pop_o        = rst_ni & pop_s;
    assign stk_idx_in_o     = rst_ni ? idx_in_s : '0;
    assign unassign_valid_o = rst_ni & unassign_valid_s;
    assign unassign_var_o   = rst_ni ? unassign_var_s : '0;
    assign flip_valid_o     = rst_ni & flip_valid_s;
    assign flip_var_o       = rst_ni ? flip_var_s : '0;
    assign flip_val_o       = rst_ni & flip_val_s;
    assign busy_o           = rst_ni & (state_q != ST_IDLE);
    assign unsat_o          = rst_ni & (state_q == ST_UNSAT);
    assign overflow_o       = rst_ni & overflow_q;

endmodule

// File: tb/tb_backtrack_ctrl.sv
module tb_backtrack_ctrl;

    localparam int NV = 64;
    localparam int NB = 6;

    logic          clk = 1'b0;
    logic          rst_ni = 1'b0;
    logic          decide_valid = 1'b0;
    logic [NB-1:0] decide_var = '0;
    logic          decide_val = 1'b0;
    logic          conflict = 1'b0;
    logic          stk_push, stk_pop;
    logic [NB-1:0] stk_idx_in, stk_idx_out;
    logic          unassign_valid, flip_valid, flip_val;
    logic [NB-1:0] unassign_var, flip_var;
    logic          busy, unsat, overflow;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    backtrack_ctrl #(.MAX_VARS(NV), .MAX_VARS_BITS(NB)) dut (
        .clk_i(clk), .rst_ni(rst_ni),
        .decide_valid_i(decide_valid), .decide_var_i(decide_var),
        .decide_val_i(decide_val), .conflict_i(conflict),
        .stk_push_o(stk_push), .stk_pop_o(stk_pop), .stk_idx_in_o(stk_idx_in),
        .stk_idx_out_i(stk_idx_out),
        .unassign_valid_o(unassign_valid), .unassign_var_o(unassign_var),
        .flip_valid_o(flip_valid), .flip_var_o(flip_var), .flip_val_o(flip_val),
        .busy_o(busy), .unsat_o(unsat), .overflow_o(overflow)
    );

    // Decision-stack environment model: cleared by reset, top is combinational.
    logic [NB-1:0] stk_mem [0:NV];
    int            sp;
    always @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) sp <= 0;
        else if (stk_push && sp <= NV) begin
            stk_mem[sp] <= stk_idx_in;
            sp <= sp + 1;
        end else if (stk_pop && sp > 0) sp <= sp - 1;
    end
    assign stk_idx_out = (sp > 0) ? stk_mem[sp-1] : '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Apply inputs on the falling edge and settle before checking.
    task automatic step(input logic dv, input logic [NB-1:0] v, input logic vl, input logic cf);
        @(negedge clk);
        decide_valid = dv;
        decide_var   = v;
        decide_val   = vl;
        conflict     = cf;
        #1;
    endtask

    initial begin
        // Reset state, with a decision presented while reset is held.
        decide_valid = 1'b1; decide_var = 6'd9;
        #2;
        chk("rst_push", stk_push, 0);
        chk("rst_idx", stk_idx_in, 0);
        chk("rst_busy", busy, 0);
        chk("rst_unsat", unsat, 0);
        chk("rst_ovf", overflow, 0);
        @(negedge clk); rst_ni = 1'b1; decide_valid = 1'b0;

        // Push 3 (val 1) and 7 (val 0).
        step(1'b1, 6'd3, 1'b1, 1'b0);
        chk("push3", stk_push, 1);
        chk("push3_idx", stk_idx_in, 3);
        chk("push3_pop", stk_pop, 0);
        step(1'b1, 6'd7, 1'b0, 1'b0);
        chk("push7", stk_push, 1);
        chk("push7_idx", stk_idx_in, 7);

        // First conflict: pop 7, flip 7 to 1.
        step(1'b0, 6'd0, 1'b0, 1'b1);
        chk("cf1_push", stk_push, 0);
        chk("cf1_busy", busy, 0);
        step(1'b0, 6'd0, 1'b0, 1'b0);
        chk("bt1_busy", busy, 1);
        chk("bt1_pop", stk_pop, 1);
        chk("bt1_unas", unassign_valid, 0);
        chk("bt1_push", stk_push, 0);
        step(1'b0, 6'd0, 1'b0, 1'b0);
        chk("fl1_valid", flip_valid, 1);
        chk("fl1_var", flip_var, 7);
        chk("fl1_val", flip_val, 1);
        chk("fl1_push", stk_push, 1);
        chk("fl1_idx", stk_idx_in, 7);
        chk("fl1_pop", stk_pop, 0);
        chk("fl1_busy", busy, 1);
        step(1'b0, 6'd0, 1'b0, 1'b0);
        chk("id1_busy", busy, 0);
        chk("id1_flip", flip_valid, 0);

        // Second conflict: unassign 7, then flip 3 to 0.
        step(1'b0, 6'd0, 1'b0, 1'b1);
        step(1'b0, 6'd0, 1'b0, 1'b0);
        chk("bt2a_pop", stk_pop, 1);
        chk("bt2a_unas", unassign_valid, 1);
        chk("bt2a_uvar", unassign_var, 7);
        step(1'b0, 6'd0, 1'b0, 1'b0);
        chk("bt2b_pop", stk_pop, 1);
        chk("bt2b_unas", unassign_valid, 0);
        step(1'b0, 6'd0, 1'b0, 1'b0);
        chk("fl2_valid", flip_valid, 1);
        chk("fl2_var", flip_var, 3);
        chk("fl2_val", flip_val, 0);
        chk("fl2_idx", stk_idx_in, 3);
        step(1'b0, 6'd0, 1'b0, 1'b0);
        chk("id2_busy", busy, 0);

        // Conflict together with decision of var 5: no push, then unwind to UNSAT.
        step(1'b1, 6'd5, 1'b1, 1'b1);
        chk("cfdv_push", stk_push, 0);
        step(1'b0, 6'd0, 1'b0, 1'b0);
        chk("bt3a_pop", stk_pop, 1);
        chk("bt3a_unas", unassign_valid, 1);
        chk("bt3a_uvar", unassign_var, 3);
        step(1'b0, 6'd0, 1'b0, 1'b0);
        chk("bt3b_pop", stk_pop, 0);
        chk("bt3b_busy", busy, 1);
        chk("bt3b_unas", unassign_valid, 0);
        step(1'b1, 6'd9, 1'b1, 1'b0);
        chk("unsat", unsat, 1);
        chk("unsat_push", stk_push, 0);
        chk("unsat_busy", busy, 1);
        step(1'b0, 6'd0, 1'b0, 1'b1);
        chk("unsat_pop", stk_pop, 0);
        step(1'b0, 6'd0, 1'b0, 1'b0);
        chk("unsat_sticky", unsat, 1);

        // Reset clears UNSAT immediately.
        rst_ni = 1'b0;
        #1;
        chk("rst2_unsat", unsat, 0);
        chk("rst2_busy", busy, 0);
        @(negedge clk); rst_ni = 1'b1;

        // Fill all levels, then one more decision overflows.
        for (int i = 0; i < NV; i++) begin
            step(1'b1, NB'(i), 1'(i), 1'b0);
            chk("fill_push", stk_push, 1);
        end
        step(1'b1, 6'd11, 1'b0, 1'b0);
        chk("ovf_push", stk_push, 0);
        chk("ovf_pre", overflow, 0);
        step(1'b0, 6'd0, 1'b0, 1'b0);
        chk("ovf_flag", overflow, 1);

        // Depth is MAX_VARS: top level (var 63, val 1) flips to 0.
        step(1'b0, 6'd0, 1'b0, 1'b1);
        step(1'b0, 6'd0, 1'b0, 1'b0);
        chk("bt4_pop", stk_pop, 1);
        chk("bt4_unas", unassign_valid, 0);
        step(1'b0, 6'd0, 1'b0, 1'b0);
        chk("fl4_var", flip_var, 63);
        chk("fl4_val", flip_val, 0);
        step(1'b0, 6'd0, 1'b0, 1'b0);
        chk("ovf_sticky", overflow, 1);

        // Reset dropped mid-backtrack.
        step(1'b0, 6'd0, 1'b0, 1'b1);
        step(1'b0, 6'd0, 1'b0, 1'b0);
        chk("bt5_unas", unassign_valid, 1);
        chk("bt5_uvar", unassign_var, 63);
        rst_ni = 1'b0;
        #1;
        chk("rst3_pop", stk_pop, 0);
        chk("rst3_unas", unassign_valid, 0);
        chk("rst3_uvar", unassign_var, 0);
        chk("rst3_busy", busy, 0);
        chk("rst3_unsat", unsat, 0);
        chk("rst3_ovf", overflow, 0);
        @(negedge clk); rst_ni = 1'b1;

        // After reset, var 2 is pushed at depth 0 and flips on conflict.
        step(1'b1, 6'd2, 1'b1, 1'b0);
        chk("post_push", stk_push, 1);
        chk("post_idx", stk_idx_in, 2);
        step(1'b0, 6'd0, 1'b0, 1'b1);
        step(1'b0, 6'd0, 1'b0, 1'b0);
        chk("bt6_pop", stk_pop, 1);
        chk("bt6_unas", unassign_valid, 0);
        step(1'b0, 6'd0, 1'b0, 1'b0);
        chk("fl6_var", flip_var, 2);
        chk("fl6_val", flip_val, 0);
        step(1'b0, 6'd0, 1'b0, 1'b0);
        chk("id6_busy", busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
